crc_sched: RTL

CRC_SCHED -- requirements
Module: crc_sched

---
 rtl/crc_sched_pkg.sv | 23 ++
 rtl/crc_sched_if.sv | 32 +++
 rtl/crc_sched_rr_arb2.sv | 20 ++
 rtl/crc_sched.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the CRC engine scheduler.
package crc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FEED,
    S_FLUSH,
    S_DRAIN,
    S_RESULT
  } state_e;

  localparam logic ID_TX = 1'b0;
  localparam logic ID_RX = 1'b1;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/crc_sched_if.sv
// Requester, engine and result signals of the CRC scheduler, bundled as one interface.
interface crc_sched_if;
  logic [1:0]  req;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic [1:0]  valid;
  logic [1:0]  last;
  logic [1:0]  gnt;
  logic [1:0]  ready;
  logic        eng_init;
  logic        eng_en;
  logic        eng_valid;
  logic [31:0] eng_data;
  logic [31:0] eng_crc;
  logic [31:0] res_crc;
  logic        res_valid;
  logic        res_id;
  logic        res_err;
  logic        busy;

  modport slave (
    input  req, tx_data, rx_data, valid, last, eng_crc,
    output gnt, ready, eng_init, eng_en, eng_valid, eng_data,
           res_crc, res_valid, res_id, res_err, busy
  );

  modport master (
    output req, tx_data, rx_data, valid, last, eng_crc,
    input  gnt, ready, eng_init, eng_en, eng_valid, eng_data,
           res_crc, res_valid, res_id, res_err, busy
  );
endinterface

// File: rtl/crc_sched_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arb2
  import crc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = id_onehot(~last_id);
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/crc_sched.sv
// Shares one CRC engine between TX and RX frame sources, one whole frame at a time.
//  state  | meaning
//  IDLE   | no owner, arbitrating requests
//  INIT   | one-cycle engine reload, word counter cleared
//  FEED   | owner words forwarded to the engine
//  FLUSH  | frame overran MAX_WORDS, words discarded up to last
//  DRAIN  | ENG_LAT cycles waiting for the engine result
//  RESULT | one-cycle result strobe, owner becomes last-served
module crc_sched
  import crc_sched_pkg::*;
#(
  parameter int ENG_LAT   = 2,
  parameter int MAX_WORDS = 380
) (
  input logic          clk,
  input logic          rst_n,
  crc_sched_if.slave   bus
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int LW = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ENG_LAT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_id_q, last_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic        err_q, err_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        eng_init_q, eng_init_d;
  logic        busy_q, busy_d;
  logic        res_valid_q, res_valid_d;
  logic        res_id_q, res_id_d;
  logic        res_err_q, res_err_d;
  logic [31:0] res_crc_q, res_crc_d;

  logic [1:0]  arb_gnt;
  logic        in_feed, in_flush, own_valid, own_last, accept;
  logic [31:0] own_data;

  rr_arb2 u_arb (
    .req     (bus.req),
    .last_id (last_id_q),
    .grant   (arb_gnt)
  );

  assign in_feed   = (state_q == S_FEED);
  assign in_flush  = (state_q == S_FLUSH);
  assign own_valid = bus.valid[owner_q];
  assign own_last  = bus.last[owner_q];
  assign own_data  = owner_q ? bus.rx_data : bus.tx_data;
  assign accept    = (in_feed || in_flush) && own_valid;

  // Handshake paths stay combinational so a word moves in the cycle it is offered.
  assign bus.ready     = (in_feed || in_flush) ? id_onehot(owner_q) : 2'b00;
  assign bus.eng_en    = in_feed || in_flush || (state_q == S_DRAIN);
  assign bus.eng_valid = in_feed && own_valid;
  assign bus.eng_data  = in_feed ? own_data : 32'h0;

  assign bus.gnt       = gnt_q;
  assign bus.eng_init  = eng_init_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_crc   = res_crc_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    err_d     = err_q;
    res_id_d  = res_id_q;
    res_err_d = res_err_q;
    res_crc_d = res_crc_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          owner_d = arb_gnt[1] ? ID_RX : ID_TX;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (own_last) begin
            lat_d   = LAT_LOAD;
            state_d = S_DRAIN;
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (accept && own_last) begin
          lat_d   = LAT_LOAD;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Capture on the way into RESULT so the result fields align with res_valid.
        if (lat_q == '0) begin
          res_crc_d = bus.eng_crc;
          res_id_d  = owner_q;
          res_err_d = err_q;
          state_d   = S_RESULT;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RESULT: begin
        last_id_d = owner_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    gnt_d       = (state_d != S_IDLE) ? id_onehot(owner_d) : 2'b00;
    eng_init_d  = (state_d == S_INIT);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= ID_TX;
      last_id_q   <= ID_RX;
      cnt_q       <= '0;
      lat_q       <= '0;
      err_q       <= 1'b0;
      gnt_q       <= 2'b00;
      eng_init_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
      res_crc_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      eng_init_q  <= eng_init_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      res_crc_q   <= res_crc_d;
    end
  end

endmodule
